pixel_row_serializer: RTL and testbench
=======================================

Name: pixel_row_serializer

Overview:
- Downstream stage of the pixel sensor array.
- Accepts one complete row of PIXEL_BITS-wide pixel values in parallel.
- Double-buffers rows and streams each one out OUTPUT_BUS_WIDTH pixels per beat over a valid/ready interface, with row and frame markers.
- Lets the array deliver the next row while the current row is still being read out.

Parameters:
- PIXEL_ARRAY_HEIGHT, 12, rows per frame.
- PIXEL_ARRAY_WIDTH, 24, pixels per row; must be an integer multiple of OUTPUT_BUS_WIDTH.
- PIXEL_BITS, 8, bits per pixel.
- OUTPUT_BUS_WIDTH, 8, pixels per output beat. Derived: BEATS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH (3 at defaults).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- row_data  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  full row; pixel i occupies bits [i*PIXEL_BITS +: PIXEL_BITS].
- row_valid  in  1  row_data is valid.
- row_ready  out  1  a row buffer is free.
- frame_abort  in  1  synchronous flush of buffered rows and counters.
- out_data  out  OUTPUT_BUS_WIDTH*PIXEL_BITS  beat k, lane j = pixel k*OUTPUT_BUS_WIDTH+j.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_sol  out  1  first beat of a row.
- out_eol  out  1  last beat of a row.
- out_eof  out  1  last beat of last row of frame.
- out_row  out  $clog2(PIXEL_ARRAY_HEIGHT)  row index of current beat.

Behaviour:
- Reset (reset low, async): count=0, wr_ptr=0, rd_ptr=0, beat=0, row counter=0. Outputs: out_valid=0, out_data=0, out_sol/out_eol/out_eof=0, out_row=0, row_ready=1. Buffer contents are don't-care.
- Storage: two row buffers A/B. count (0..2) = number of occupied buffers.
- row_ready = (count<2). Driven only from registers; no combinational path from out_ready or row_valid.
- Row accept: row_valid && row_ready at an edge. row_data is captured into buffer[wr_ptr], wr_ptr toggles, count increments.
- Latency: a row accepted at edge n into an empty block gives out_valid=1 immediately after edge n, with beat 0 of that row on out_data.
- Output: out_valid = (count>0). out_data selects lane slice beat of buffer[rd_ptr] (combinational mux from registers).
- Beat transfer: out_valid && out_ready at an edge.
  - If beat<BEATS-1: beat increments.
  - Else: beat=0, rd_ptr toggles, count decrements, row counter advances.
- Markers (combinational from state, valid only while out_valid=1, otherwise 0):
  - out_sol = (beat==0)
  - out_eol = (beat==BEATS-1)
  - out_eof = out_eol && (row==PIXEL_ARRAY_HEIGHT-1)
- Row counter: increments on last-beat transfer; after PIXEL_ARRAY_HEIGHT-1 it wraps to 0. out_row equals the counter.
- Stability: while out_valid=1 and out_ready=0, out_data and all markers hold unchanged, even if a new row is accepted that cycle.
- Simultaneous accept + last-beat release: count unchanged, both pointers toggle. Zero-bubble streaming when count=1.
- count=2: row_ready=0, and row_valid is ignored with no capture. Upstream must hold row_data.
- frame_abort=1 at an edge:
  - count=0, beat=0, row counter=0, pointers=0.
  - Takes priority over a simultaneous accept and beat transfer; neither takes effect.
  - out_valid=0 the following cycle.
- Reset asserted mid-row: immediate return to reset state. The partially sent row is lost with no eol.
- No combinational loop between out_ready and out_valid.

Test Plan:
- Reset then idle -> out_valid=0, row_ready=1, out_row=0, all markers 0.
- Row with pixel i=i (0..23), out_ready=1 -> 3 consecutive beats: lanes 0..7, 8..15, 16..23. out_sol on beat 0, out_eol on beat 2, out_valid rising one edge after accept.
- Same row, out_ready toggled 1,0,0,1,1 -> exactly 3 transfers, out_data held constant during stalls, no duplicated or skipped beat.
- out_ready=0, offer 3 rows -> first two accepted (count=2), row_ready=0, third held. Release out_ready -> rows 0 then 1 emerge in order, third accepted on the cycle after row 0's last beat.
- 12 rows streamed continuously -> out_row 0..11. out_eof only on row 11 beat 2. Row 12 emerges with out_row=0 and out_sol=1, no bubble between rows.
- frame_abort at beat 1 of row 3 with count=2 -> next cycle out_valid=0, row_ready=1. The next accepted row emerges as out_row=0, beat 0.

Source files
------------

// File: rtl/pixel_row_serializer.sv
// Double-buffered row serializer: captures a full pixel row in parallel and
// streams it out OUTPUT_BUS_WIDTH pixels per beat with row/frame markers.
module pixel_row_serializer #(
    parameter int PIXEL_ARRAY_HEIGHT = 12,
    parameter int PIXEL_ARRAY_WIDTH  = 24,
    parameter int PIXEL_BITS         = 8,
    parameter int OUTPUT_BUS_WIDTH   = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   row_data,
    input  logic                                      row_valid,
    output logic                                      row_ready,
    input  logic                                      frame_abort,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]    out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_sol,
    output logic                                      out_eol,
    output logic                                      out_eof,
    output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]     out_row
);

    localparam int BEATS    = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W    = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int ROW_BITS = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int LANE_W   = OUTPUT_BUS_WIDTH * PIXEL_BITS;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

    logic [ROW_BITS-1:0] buf_q [2];
    logic [ROW_BITS-1:0] buf_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q,  count_d;
    logic [BEAT_W-1:0]   beat_q,   beat_d;
    logic [ROW_W-1:0]    row_q,    row_d;

    logic accept;
    logic xfer;
    logic release_row;

    always_comb begin
        row_ready   = (count_q < 2'd2);
        out_valid   = (count_q != 2'd0);
        accept      = row_valid && row_ready && !frame_abort;
        xfer        = out_valid && out_ready && !frame_abort;
        release_row = xfer && (beat_q == LAST_BEAT);

        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        row_d    = row_q;

        if (frame_abort) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            beat_d   = '0;
            row_d    = '0;
        end else begin
            if (accept) begin
                buf_d[wr_ptr_q] = row_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (xfer) begin
                if (release_row) begin
                    beat_d   = '0;
                    rd_ptr_d = ~rd_ptr_q;
                    row_d    = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            // Accept and release in the same cycle leave occupancy unchanged.
            case ({accept, release_row})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            beat_q   <= '0;
            row_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            row_q    <= row_d;
        end
    end

    // Row storage needs no reset; its contents only reach out_data while occupied.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        out_data = '0;
        out_sol  = 1'b0;
        out_eol  = 1'b0;
        out_eof  = 1'b0;
        out_row  = row_q;
        if (out_valid) begin
            out_data = buf_q[rd_ptr_q][beat_q*LANE_W +: LANE_W];
            out_sol  = (beat_q == '0);
            out_eol  = (beat_q == LAST_BEAT);
            out_eof  = (beat_q == LAST_BEAT) && (row_q == LAST_ROW);
        end
    end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// Directed self-checking bench for pixel_row_serializer: every cycle's outputs
// are compared against hand-derived beats, markers, row indices and row_ready.
module tb_pixel_row_serializer;

    localparam int H        = 12;
    localparam int W        = 24;
    localparam int PB       = 8;
    localparam int OBW      = 8;
    localparam int ROWW     = 4;
    localparam int ROWBITS  = W * PB;
    localparam int LANEBITS = OBW * PB;
    localparam int VW       = 9 + LANEBITS;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [ROWBITS-1:0]  row_data = '0;
    logic                row_valid = 1'b0;
    logic                row_ready;
    logic                frame_abort = 1'b0;
    logic [LANEBITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_sol;
    logic                out_eol;
    logic                out_eof;
    logic [ROWW-1:0]     out_row;

    int vectors = 0;
    int miscompares = 0;

    pixel_row_serializer #(
        .PIXEL_ARRAY_HEIGHT(H),
        .PIXEL_ARRAY_WIDTH (W),
        .PIXEL_BITS        (PB),
        .OUTPUT_BUS_WIDTH  (OBW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .frame_abort(frame_abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .out_row    (out_row)
    );

    always #5 clk = ~clk;

    // Pixel i of a row carries seed+i, so each beat's lanes are predictable.
    function automatic logic [ROWBITS-1:0] makeRow(input logic [7:0] seed);
        logic [ROWBITS-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i*PB +: PB] = seed + 8'(i);
        return r;
    endfunction

    function automatic logic [LANEBITS-1:0] expBeat(input logic [7:0] seed, input int k);
        logic [LANEBITS-1:0] d;
        d = '0;
        for (int j = 0; j < OBW; j++) d[j*PB +: PB] = seed + 8'(k*OBW + j);
        return d;
    endfunction

    function automatic logic [7:0] seedOf(input int n);
        return 8'(n*29 + 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [ROWBITS-1:0] rd,
                                 input logic ordy, input logic abort);
        row_valid   = rv;
        row_data    = rd;
        out_ready   = ordy;
        frame_abort = abort;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic es,
                               input logic ee, input logic ef, input logic [ROWW-1:0] er,
                               input logic erdy, input logic [LANEBITS-1:0] ed);
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        obs = {out_valid, out_sol, out_eol, out_eof, out_row, row_ready, out_data};
        exp = {ev, es, ee, ef, er, erdy, ed};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed={v,sol,eol,eof,row,rdy,data}=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input int row);
        checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0, ROWW'(row), 1'b1, '0);
    endtask

    task automatic checkBeat(input string tag, input logic [7:0] seed, input int k,
                             input int row, input logic rdy);
        checkOutput(tag, 1'b1, k == 0, k == 2, (k == 2) && (row == H-1),
                    ROWW'(row), rdy, expBeat(seed, k));
    endtask

    // Streams n rows with out_ready held high, tracking occupancy so the
    // expected row_ready and the upstream handshake never depend on the DUT.
    task automatic streamRows(input int n, input int off, input int startRow);
        int cnt;
        int e;
        int sent;
        int cyc;
        int r;
        int b;
        logic rv;
        logic acc;
        logic rel;
        cnt = 0; e = 0; sent = 0; cyc = 0;
        while (e < n*3 && cyc < n*3 + 10) begin
            rv = (sent < n);
            applyStimulus(rv, makeRow(seedOf(sent + off)), 1'b1, 1'b0);
            r = e / 3;
            b = e % 3;
            if (cnt > 0)
                checkBeat($sformatf("stream_r%0d_b%0d", r, b), seedOf(r + off), b,
                          (startRow + r) % H, cnt < 2);
            else
                checkIdle($sformatf("stream_idle_c%0d", cyc), (startRow + r) % H);
            tick();
            acc = rv && (cnt < 2);
            rel = (cnt > 0) && (b == 2);
            if (cnt > 0) e++;
            cnt = cnt + (acc ? 1 : 0) - (rel ? 1 : 0);
            if (acc) sent++;
            cyc++;
        end
        vectors++;
        assert (e == n*3) else begin
            miscompares++;
            $error("[TB] FAIL stream_timeout beats=%0d expected=%0d", e, n*3);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state, checked while reset is still asserted and after release.
        #1 reset = 1'b0;
        #2 checkIdle("in_reset", 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        checkIdle("idle_after_reset", 0);

        // Pixel i = i, consumer always ready: three back-to-back beats.
        applyStimulus(1'b1, makeRow(8'h00), 1'b1, 1'b0);
        checkIdle("pre_accept", 0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkBeat("t2_b0", 8'h00, 0, 0, 1'b1);
        tick();
        checkBeat("t2_b1", 8'h00, 1, 0, 1'b1);
        tick();
        checkBeat("t2_b2", 8'h00, 2, 0, 1'b1);
        tick();
        checkIdle("t2_done", 1);

        // out_ready pattern 1,0,0,1,1: beats hold during the stall.
        applyStimulus(1'b1, makeRow(8'h40), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkBeat("t3_c0", 8'h40, 0, 1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkBeat("t3_c1_stall", 8'h40, 1, 1, 1'b1);
        tick();
        checkBeat("t3_c2_stall", 8'h40, 1, 1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkBeat("t3_c3", 8'h40, 1, 1, 1'b1);
        tick();
        checkBeat("t3_c4", 8'h40, 2, 1, 1'b1);
        tick();
        checkIdle("t3_done", 2);

        // Backpressure: two rows fill both buffers, the third waits.
        applyStimulus(1'b1, makeRow(8'h80), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, makeRow(8'hA0), 1'b0, 1'b0);
        checkBeat("t4_one_buffered", 8'h80, 0, 2, 1'b1);
        tick();
        applyStimulus(1'b1, makeRow(8'hC0), 1'b0, 1'b0);
        checkBeat("t4_full", 8'h80, 0, 2, 1'b0);
        tick();
        checkBeat("t4_third_held", 8'h80, 0, 2, 1'b0);
        applyStimulus(1'b1, makeRow(8'hC0), 1'b1, 1'b0);
        tick();
        checkBeat("t4_r0_b1", 8'h80, 1, 2, 1'b0);
        tick();
        checkBeat("t4_r0_b2", 8'h80, 2, 2, 1'b0);
        tick();
        checkBeat("t4_r1_b0", 8'hA0, 0, 3, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkBeat("t4_r1_b1", 8'hA0, 1, 3, 1'b0);
        tick();
        checkBeat("t4_r1_b2", 8'hA0, 2, 3, 1'b0);
        tick();
        checkBeat("t4_r2_b0", 8'hC0, 0, 4, 1'b1);
        tick();
        checkBeat("t4_r2_b1", 8'hC0, 1, 4, 1'b1);
        tick();
        checkBeat("t4_r2_b2", 8'hC0, 2, 4, 1'b1);
        tick();
        checkIdle("t4_done", 5);

        // Abort while idle zeroes the row counter, then a full frame plus one row.
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkIdle("t5_abort_idle", 0);
        streamRows(13, 0, 0);
        checkIdle("t5_done", 1);

        // Abort at beat 1 of row 3 with both buffers full.
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        streamRows(3, 20, 0);
        applyStimulus(1'b1, makeRow(8'h11), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, makeRow(8'h22), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkBeat("t6_full", 8'h11, 0, 3, 1'b0);
        tick();
        checkBeat("t6_b1", 8'h11, 1, 3, 1'b0);
        applyStimulus(1'b1, makeRow(8'h33), 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkIdle("t6_aborted", 0);
        applyStimulus(1'b1, makeRow(8'h33), 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkBeat("t6_new_b0", 8'h33, 0, 0, 1'b1);
        tick();
        checkBeat("t6_new_b1", 8'h33, 1, 0, 1'b1);
        tick();
        checkBeat("t6_new_b2", 8'h33, 2, 0, 1'b1);
        tick();
        checkIdle("t6_done", 1);

        // Reset asserted mid-row drops the partial row immediately.
        applyStimulus(1'b1, makeRow(8'h44), 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkBeat("t7_b1", 8'h44, 1, 1, 1'b1);
        #2 reset = 1'b0;
        #1 checkIdle("t7_reset_mid", 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkIdle("t7_after_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
